// File: rtl/rf_exec_ctrl.sv
// Execution sequencer that reads two operands from the 8x16 register file and writes an ALU result back.
// Optional macro RF_EXEC_OVERLAP_EN lets a new instruction be accepted during WRITE.
module rf_exec_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [0:2]        op,
    input  logic [0:ADDR_W-1] rs_a,
    input  logic [0:ADDR_W-1] rs_b,
    input  logic [0:ADDR_W-1] rd,
    output logic [0:ADDR_W-1] rd_addr_a,
    output logic [0:ADDR_W-1] rd_addr_b,
    input  logic [0:DATA_W-1] rf_a,
    input  logic [0:DATA_W-1] rf_b,
    output logic              wr,
    output logic [0:ADDR_W-1] wr_addr,
    output logic [0:DATA_W-1] d_in,
    output logic              done,
    output logic              flag_z,
    output logic              flag_c
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

    state_t state, state_next;

    logic              accept;
    logic [0:2]        op_q;
    logic [0:ADDR_W-1] rd_q;
    logic [0:DATA_W-1] a_q, b_q;
    logic [0:DATA_W-1] result_q;
    logic              z_q, c_q;
    logic [0:DATA_W-1] alu_res;
    logic              alu_c;
    logic [0:DATA_W]   sum, diff;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        wr          = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_next = READ;
            end
            READ: state_next = EXEC;
            EXEC: state_next = WRITE;
            WRITE: begin
                wr = 1'b1;
`ifdef RF_EXEC_OVERLAP_EN
                // The next READ follows the write edge, so accepting here is hazard-free.
                instr_ready = 1'b1;
                state_next  = instr_valid ? READ : IDLE;
`else
                state_next  = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept  = instr_ready && instr_valid;
    assign wr_addr = rd_q;
    assign d_in    = result_q;

    // Bit 0 of the widened sum/difference is the carry-out or borrow.
    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_q)
            3'b000: begin alu_res = sum[1:DATA_W];  alu_c = sum[0];  end
            3'b001: begin alu_res = diff[1:DATA_W]; alu_c = diff[0]; end
            3'b010: alu_res = a_q & b_q;
            3'b011: alu_res = a_q | b_q;
            3'b100: alu_res = a_q ^ b_q;
            3'b101: alu_res = ~a_q;
            3'b110: begin alu_res = a_q << 1; alu_c = a_q[0];        end
            3'b111: begin alu_res = a_q >> 1; alu_c = a_q[DATA_W-1]; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            rd_q      <= '0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            done      <= 1'b0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
        end else begin
            done <= (state == WRITE);
            // Read addresses double as the latched source fields and hold outside READ.
            if (accept) begin
                op_q      <= op;
                rd_q      <= rd;
                rd_addr_a <= rs_a;
                rd_addr_b <= rs_b;
            end
            if (state == READ) begin
                a_q <= rf_a;
                b_q <= rf_b;
            end
            if (state == EXEC) begin
                result_q <= alu_res;
                z_q      <= (alu_res == '0);
                c_q      <= alu_c;
            end
            if (state == WRITE) begin
                flag_z <= z_q;
                flag_c <= c_q;
            end
        end
    end

endmodule

// File: tb/tb_rf_exec_ctrl.sv
// Testbench for rf_exec_ctrl with a behavioural 8x16 register file closing the write-back loop.
// Expected writes are queued at issue time and checked by a monitor when the DUT writes back.
module tb_rf_exec_ctrl;

    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
                           OP_XOR = 3'd4, OP_NOT = 3'd5, OP_SHL = 3'd6, OP_SHR = 3'd7;
`ifdef RF_EXEC_OVERLAP_EN
    localparam int B2B_GAP = 3;
`else
    localparam int B2B_GAP = 4;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [0:2]  op;
    logic [0:2]  rs_a, rs_b, rd;
    logic [0:2]  rd_addr_a, rd_addr_b;
    logic [0:15] rf_a, rf_b;
    logic        wr;
    logic [0:2]  wr_addr;
    logic [0:15] d_in;
    logic        done, flag_z, flag_c;

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] val;
        logic        z;
        logic        c;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        pend;
    logic [15:0] rf_mem [0:7];
    logic [15:0] mregs  [0:7];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wr_cyc = 0;
    int          writes_seen = 0;
    int          dones_seen = 0;
    bit          flag_pending = 1'b0;

    rf_exec_ctrl dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .op(op), .rs_a(rs_a), .rs_b(rs_b), .rd(rd),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rf_a(rf_a), .rf_b(rf_b),
        .wr(wr), .wr_addr(wr_addr), .d_in(d_in),
        .done(done), .flag_z(flag_z), .flag_c(flag_c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file: combinational reads, synchronous write, cleared by the shared reset.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= 16'h0000;
        end else if (wr) begin
            rf_mem[wr_addr] <= d_in;
        end
    end
    assign rf_a = rf_mem[rd_addr_a];
    assign rf_b = rf_mem[rd_addr_b];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic void model_alu(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                                      output logic [15:0] v, output logic c);
        int unsigned wide;
        c = 1'b0;
        case (o)
            OP_ADD: begin wide = int'(a) + int'(b); v = wide[15:0]; c = (wide > 32'hFFFF); end
            OP_SUB: begin v = a - b; c = (a < b); end
            OP_AND: v = a & b;
            OP_OR:  v = a | b;
            OP_XOR: v = a ^ b;
            OP_NOT: v = ~a;
            OP_SHL: begin v = {a[14:0], 1'b0}; c = a[15]; end
            default: begin v = {1'b0, a[15:1]}; c = a[0]; end
        endcase
    endfunction

    function automatic exp_t predict(input logic [2:0] o, input logic [2:0] a, input logic [2:0] b,
                                     input logic [2:0] d);
        exp_t e;
        model_alu(o, mregs[a], mregs[b], e.val, e.c);
        e.z   = (e.val == 16'h0000);
        e.rd  = d;
        e.acc = 0;
        return e;
    endfunction

    // Scoreboard monitor, sampled on the falling edge away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (wr && done) check("wr_done_overlap", 1, 0);
            if (done) begin
                dones_seen++;
                if (!flag_pending) begin
                    check("unexpected_done", done, 0);
                end else begin
                    check("done_latency", cyc - wr_cyc, 1);
                    check("flag_z", flag_z, pend.z);
                    check("flag_c", flag_c, pend.c);
                    check("rf_contents", rf_mem[pend.rd], pend.val);
                    flag_pending = 1'b0;
                end
            end
            if (wr) begin
                writes_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", wr, 0);
                end else begin
                    pend = exp_q.pop_front();
                    check("wr_latency", cyc - pend.acc, 2);
                    check("wr_addr", wr_addr, pend.rd);
                    check("d_in", d_in, pend.val);
                    wr_cyc       = cyc;
                    flag_pending = 1'b1;
                end
            end
        end
    end

    task automatic waitReady();
        int n = 0;
        while (!instr_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!instr_ready) check("ready_timeout", instr_ready, 1);
    endtask

    task automatic applyStimulus(input logic [2:0] o, input logic [2:0] a, input logic [2:0] b,
                                 input logic [2:0] d, input bit hold);
        exp_t e;
        waitReady();
        op = o; rs_a = a; rs_b = b; rd = d;
        instr_valid = 1'b1;
        e = predict(o, a, b, d);
        @(posedge clk); #1;
        e.acc = cyc;
        exp_q.push_back(e);
        mregs[d] = e.val;
        if (hold) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
    endtask

    task automatic checkOutput();
        int n = 0;
        while ((exp_q.size() != 0 || flag_pending) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_timeout", (exp_q.size() == 0 && !flag_pending), 1);
    endtask

    initial begin
        int   ws, ds, c0;
        exp_t e1, e2;
        #200000;
        $display("[TB] FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int   ws, ds, c0;
        exp_t e1, e2;
        reset = 1'b1; instr_valid = 1'b0;
        op = '0; rs_a = '0; rs_b = '0; rd = '0;
        for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", instr_ready, 1);
        check("rst_wr", wr, 0);
        check("rst_done", done, 0);
        check("rst_flag_z", flag_z, 0);
        check("rst_flag_c", flag_c, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_d_in", d_in, 0);
        reset = 1'b0;

        $display("[TB] step 1: NOT r0 -> r1");
        applyStimulus(OP_NOT, 3'd0, 3'd0, 3'd1, 1'b0);
        checkOutput();
        check("r1_value", rf_mem[1], 16'hFFFF);

        $display("[TB] step 2: SHR r1 -> r2, ADD r1,r1 -> r3");
        applyStimulus(OP_SHR, 3'd1, 3'd0, 3'd2, 1'b0);
        checkOutput();
        check("r2_value", rf_mem[2], 16'h7FFF);
        check("shr_flag_c", flag_c, 1);
        applyStimulus(OP_ADD, 3'd1, 3'd1, 3'd3, 1'b0);
        checkOutput();
        check("r3_value", rf_mem[3], 16'hFFFE);

        $display("[TB] step 3: SUB r2,r1 -> r4, XOR r1,r1 -> r5");
        applyStimulus(OP_SUB, 3'd2, 3'd1, 3'd4, 1'b0);
        checkOutput();
        check("r4_value", rf_mem[4], 16'h8000);
        check("sub_borrow", flag_c, 1);
        applyStimulus(OP_XOR, 3'd1, 3'd1, 3'd5, 1'b0);
        checkOutput();
        check("xor_flag_z", flag_z, 1);

        $display("[TB] step 4: SHL r3 -> r3 with instr_valid held");
        ws = writes_seen;
        applyStimulus(OP_SHL, 3'd3, 3'd0, 3'd3, 1'b1);
        checkOutput();
        repeat (4) begin @(posedge clk); #1; end
        check("one_write_per_handshake", writes_seen - ws, 1);
        check("r3_shl_value", rf_mem[3], 16'hFFFC);

        $display("[TB] step 5: reset during EXEC");
        ws = writes_seen; ds = dones_seen;
        applyStimulus(OP_ADD, 3'd1, 3'd1, 3'd6, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_wr", wr, 0);
        check("abort_done", done, 0);
        check("abort_flag_z", flag_z, 0);
        check("abort_flag_c", flag_c, 0);
        check("abort_d_in", d_in, 0);
        check("abort_wr_addr", wr_addr, 0);
        check("abort_rd_addr_a", rd_addr_a, 0);
        check("abort_ready", instr_ready, 1);
        repeat (5) begin @(posedge clk); #1; end
        check("abort_no_write", writes_seen - ws, 0);
        check("abort_no_done", dones_seen - ds, 0);
        check("abort_r6", rf_mem[6], 16'h0000);

        $display("[TB] step 6: back-to-back NOT r0 -> r1, ADD r1,r1 -> r2");
        waitReady();
        op = OP_NOT; rs_a = 3'd0; rs_b = 3'd0; rd = 3'd1;
        instr_valid = 1'b1;
        e1 = predict(OP_NOT, 3'd0, 3'd0, 3'd1);
        @(posedge clk); #1;
        e1.acc = cyc; c0 = cyc;
        exp_q.push_back(e1);
        mregs[1] = e1.val;
        op = OP_ADD; rs_a = 3'd1; rs_b = 3'd1; rd = 3'd2;
        e2 = predict(OP_ADD, 3'd1, 3'd1, 3'd2);
        waitReady();
        @(posedge clk); #1;
        e2.acc = cyc;
        exp_q.push_back(e2);
        mregs[2] = e2.val;
        instr_valid = 1'b0;
        check("b2b_gap", cyc - c0, B2B_GAP);
        checkOutput();
        check("b2b_r2", rf_mem[2], 16'hFFFE);

        $display("[TB] step 7: random instructions");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0);
            checkOutput();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
